// File: rtl/alarm_core.sv
// alarm_core: seconds prescaler, 24-hour timekeeper with a load port, and an
// alarm state machine that handles ring, snooze, stop and ring timeout.
module alarm_core #(
  parameter int TICKS_PER_SEC = 100,
  parameter int SNOOZE_SEC    = 300,
  parameter int RING_SEC      = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_time,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [5:0] sec,
  output logic       sec_tick,
  output logic       load_err,
  output logic [1:0] alarm_state,
  output logic       buzzer
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam int RW = $clog2(RING_SEC + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_SEC);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  // Timekeeper state
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hour_q, hour_d;
  logic [7:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          sec_tick_q, sec_tick_d;
  logic          load_err_q, load_err_d;

  // Alarm state
  state_t        state_q, state_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [SW-1:0] snz_q, snz_d;
  logic          match_d_q;

  logic load_ok;
  logic tick_now;
  logic match;

  assign load_ok  = (set_hour <= 8'd23) && (set_min <= 8'd59);
  assign tick_now = (presc_q == PRESC_LAST);

  // Match is taken from the registered time so the alarm fires one cycle
  // after the display shows the alarm time.
  assign match = alarm_en && (hour_q == alarm_hour) && (min_q == alarm_min)
                 && (sec_q == 6'd0);

  // Timekeeper next state: a valid load wins over the seconds advance.
  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = tick_now;
    load_err_d = 1'b0;
    if (load_time && load_ok) begin
      hour_d     = set_hour;
      min_d      = set_min;
      sec_d      = 6'd0;
      presc_d    = '0;
      sec_tick_d = 1'b0;
    end else begin
      load_err_d = load_time;
      presc_d    = tick_now ? '0 : presc_q + 1'b1;
      if (tick_now) begin
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 8'd59) begin
            min_d  = 8'd0;
            hour_d = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
          end else begin
            min_d = min_q + 8'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end
  end

  // Timekeeper registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      hour_q     <= 8'd0;
      min_q      <= 8'd0;
      sec_q      <= 6'd0;
      sec_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      load_err_q <= load_err_d;
    end
  end

  // Alarm state register, counters and match history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ring_q    <= '0;
      snz_q     <= '0;
      match_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_d;
      snz_q     <= snz_d;
      match_d_q <= match;
    end
  end

  // Alarm next state: disable beats stop, stop beats snooze, all beat ticks.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    case (state_q)
      ST_IDLE: begin
        if (match && !match_d_q) begin
          state_d = ST_RING;
          ring_d  = '0;
        end
      end
      ST_RING: begin
        if (!alarm_en || stop) begin
          state_d = ST_IDLE;
          ring_d  = '0;
        end else if (snooze) begin
          state_d = ST_SNOOZE;
          snz_d   = SNOOZE_LOAD;
        end else if (sec_tick_q) begin
          if (ring_q == RING_LAST) begin
            state_d = ST_IDLE;
            ring_d  = '0;
          end else begin
            ring_d = ring_q + 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (!alarm_en || stop) begin
          state_d = ST_IDLE;
          snz_d   = '0;
        end else if (sec_tick_q) begin
          if (snz_q <= SW'(1)) begin
            state_d = ST_RING;
            ring_d  = '0;
            snz_d   = '0;
          end else begin
            snz_d = snz_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ring_d  = '0;
        snz_d   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    hour        = hour_q;
    min         = min_q;
    sec         = sec_q;
    sec_tick    = sec_tick_q;
    load_err    = load_err_q;
    alarm_state = state_q;
    buzzer      = (state_q == ST_RING);
  end

endmodule

// File: doc/alarm_core.md
ALARM_CORE -- requirements
Module: alarm_core

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100: clk cycles per second; legal range >= 2.
REQ-002 Parameter SNOOZE_SEC, default 300: snooze duration in seconds; legal range >= 1.
REQ-003 Parameter RING_SEC, default 600: maximum ring duration in seconds before auto-stop; legal range >= 1.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 load_time  in  1  one-cycle strobe: load set_hour/set_min into the timekeeper.
REQ-007 set_hour, set_min  in  8 each  binary time preset (hour 0-23, min 0-59), from the settings memory.
REQ-008 alarm_en  in  1  alarm enable, level.
REQ-009 alarm_hour, alarm_min  in  8 each  binary alarm time, from the settings memory.
REQ-010 snooze  in  1  one-cycle strobe.
REQ-011 stop  in  1  one-cycle strobe.
REQ-012 hour  out  8  current hour, 0-23, binary.
REQ-013 min  out  8  current minute, 0-59, binary.
REQ-014 sec  out  6  current second, 0-59, binary.
REQ-015 sec_tick  out  1  one-cycle pulse per elapsed second.
REQ-016 load_err  out  1  one-cycle pulse: rejected load.
REQ-017 alarm_state  out  2  FSM state: 0=IDLE, 1=RING, 2=SNOOZE; 3 never output.
REQ-018 buzzer  out  1  high exactly while alarm_state==RING.

Function
REQ-019 Prescaler counts 0..TICKS_PER_SEC-1, wraps to 0; sec_tick is registered, high the cycle after the prescaler holds its terminal value.
REQ-020 On sec_tick, time advances by one second; sec 59->0 carries min, min 59->0 carries hour, 23:59:59 -> 00:00:00.
REQ-021 load_time with set_hour<=23 and set_min<=59: next edge hour=set_hour, min=set_min, sec=0, prescaler=0; no time advance that cycle.
REQ-022 load_time with set_hour>23 or set_min>59: time and prescaler unaffected; load_err high next cycle for one cycle.
REQ-023 load_time takes priority over a coincident sec_tick advance.
REQ-024 match = alarm_en AND hour==alarm_hour AND min==alarm_min AND sec==0, evaluated on registered outputs; match_d is its one-cycle-delayed copy.
REQ-025 IDLE -> RING on the edge where match AND NOT match_d (rising edge); ring-second counter cleared.
REQ-026 RING: ring-second counter increments per sec_tick; on reaching RING_SEC -> IDLE.
REQ-027 RING with snooze -> SNOOZE; snooze counter loaded with SNOOZE_SEC.
REQ-028 SNOOZE: counter decrements per sec_tick; on reaching 0 -> RING, ring-second counter cleared.
REQ-029 stop in RING or SNOOZE -> IDLE; stop in IDLE ignored; stop wins over a coincident snooze.
REQ-030 alarm_en low in RING or SNOOZE -> IDLE next edge, overriding all other events.
REQ-031 snooze in IDLE or SNOOZE ignored.
REQ-032 A load producing a rising match edge triggers RING exactly as counting does.
REQ-033 Counter widths are sized by ceiling log2 of their parameter; no counter overflows.

Reset
REQ-034 While reset is high: hour=0, min=0, sec=0, prescaler=0, sec_tick=0, load_err=0, alarm_state=IDLE, buzzer=0, match_d=0, snooze and ring counters=0.
REQ-035 Reset mid-RING or mid-SNOOZE returns to IDLE immediately; after release, no re-trigger unless a new rising match edge occurs.

Verification (TICKS_PER_SEC=4, SNOOZE_SEC=3, RING_SEC=5)
REQ-036 Release reset, run 8 cycles -> sec_tick pulses at cycles 4 and 8, sec=2, buzzer=0.
REQ-037 load 23:59, run 60 sec_ticks -> hour=0, min=0, sec=0 after the 60th tick.
REQ-038 alarm_en=1, alarm 07:30, load 07:29, run 60 ticks -> alarm_state=RING, buzzer=1 one cycle after outputs show 07:30:00.
REQ-039 In RING pulse snooze -> buzzer=0 next cycle, state SNOOZE; after 3 sec_ticks -> RING, buzzer=1; then 5 sec_ticks -> IDLE.
REQ-040 In RING pulse stop and snooze together -> IDLE, buzzer=0; in SNOOZE drop alarm_en -> IDLE next cycle.
REQ-041 load 24:00 at 10:15:20 -> load_err one-cycle pulse, time continues from 10:15:20; then load 12:60 -> load_err again.
